// File: rtl/dsp_prog_sequencer_if.sv
// -----------------------------------------------------------------------------
// dsp_prog_sequencer_if
//
// Bundles the host handshake, the instruction-memory read port and the
// BRAM0/BRAM1/DSP48 control outputs of dsp_prog_sequencer. Signal names keep
// the sequencer's point of view (_i = into the sequencer, _o = out of it).
//
// Modports
//   slave  : the sequencer itself
//   master : whatever drives the sequencer (host + instruction memory model)
//
// Signals
//   start_i, start_pc_i        host start request and first program address
//   imem_addr_o, imem_data_i   instruction-memory address / word (1-cycle read)
//   valid_o, busy_o, err_o     program status
//   bram0_reb_o, bram1_reb_o,
//   bram1_web_o                BRAM enables
//   alumode_o, opmode_o,
//   inmode_o                   DSP48 mode fields
//   bram1_w_addr_o, bram1_r_addr_o,
//   bram0_r_addr_o             BRAM addresses
//   hold_i                     FETCH stall, present only with DSP_SEQ_HOLD_EN
//
// Optional feature macro: DSP_SEQ_HOLD_EN
// -----------------------------------------------------------------------------
interface dsp_prog_sequencer_if #(
  parameter int ADDR_WIDTH    = 5,
  parameter int ALUMODE_WIDTH = 4,
  parameter int OPMODE_WIDTH  = 7,
  parameter int INMODE_WIDTH  = 5,
  parameter int PC_WIDTH      = 4,
  parameter int I_WIDTH       = 2 + 3*ADDR_WIDTH + ALUMODE_WIDTH + OPMODE_WIDTH + INMODE_WIDTH
);

  logic                     start_i;
  logic [PC_WIDTH-1:0]      start_pc_i;
  logic [PC_WIDTH-1:0]      imem_addr_o;
  logic [I_WIDTH-1:0]       imem_data_i;
  logic                     valid_o;
  logic                     busy_o;
  logic                     err_o;
  logic                     bram0_reb_o;
  logic                     bram1_reb_o;
  logic                     bram1_web_o;
  logic [ALUMODE_WIDTH-1:0] alumode_o;
  logic [OPMODE_WIDTH-1:0]  opmode_o;
  logic [INMODE_WIDTH-1:0]  inmode_o;
  logic [ADDR_WIDTH-1:0]    bram1_w_addr_o;
  logic [ADDR_WIDTH-1:0]    bram1_r_addr_o;
  logic [ADDR_WIDTH-1:0]    bram0_r_addr_o;

`ifdef DSP_SEQ_HOLD_EN
  logic                     hold_i;

  modport slave (
    input  start_i, start_pc_i, imem_data_i, hold_i,
    output imem_addr_o, valid_o, busy_o, err_o,
           bram0_reb_o, bram1_reb_o, bram1_web_o,
           alumode_o, opmode_o, inmode_o,
           bram1_w_addr_o, bram1_r_addr_o, bram0_r_addr_o
  );

  modport master (
    output start_i, start_pc_i, imem_data_i, hold_i,
    input  imem_addr_o, valid_o, busy_o, err_o,
           bram0_reb_o, bram1_reb_o, bram1_web_o,
           alumode_o, opmode_o, inmode_o,
           bram1_w_addr_o, bram1_r_addr_o, bram0_r_addr_o
  );
`else
  modport slave (
    input  start_i, start_pc_i, imem_data_i,
    output imem_addr_o, valid_o, busy_o, err_o,
           bram0_reb_o, bram1_reb_o, bram1_web_o,
           alumode_o, opmode_o, inmode_o,
           bram1_w_addr_o, bram1_r_addr_o, bram0_r_addr_o
  );

  modport master (
    output start_i, start_pc_i, imem_data_i,
    input  imem_addr_o, valid_o, busy_o, err_o,
           bram0_reb_o, bram1_reb_o, bram1_web_o,
           alumode_o, opmode_o, inmode_o,
           bram1_w_addr_o, bram1_r_addr_o, bram0_r_addr_o
  );
`endif

endinterface

// File: rtl/dsp_prog_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_prog_sequencer
//
// Runs a program of DSP48 instructions held in an external instruction memory.
// On an accepted start the PC is loaded from start_pc_i; each instruction goes
// through FETCH (address out), DECODE (word registered into mode/address/
// enable outputs) and EXEC_LAT cycles of EXECUTE. The program ends on an
// instruction with the "last" bit, or with err_o if the PC reaches the top of
// program space without one (the PC never wraps).
//
// Instruction word, LSB first:
//   [0] exec, [1] last, bram0_r_addr, bram1_r_addr, bram1_w_addr,
//   inmode, opmode, alumode
//
// Ports
//   clk_i   clock
//   rst_ni  asynchronous active-low reset; clears every output immediately
//   bus     dsp_prog_sequencer_if.slave (host handshake, instruction memory,
//           BRAM enables/addresses, DSP48 modes, optional hold_i)
//
// Optional feature macro: DSP_SEQ_HOLD_EN
//   defined   : hold_i=1 keeps the FSM in FETCH (enables low, PC unchanged)
//   undefined : no hold_i, FETCH always advances
// -----------------------------------------------------------------------------
module dsp_prog_sequencer #(
  parameter int ADDR_WIDTH    = 5,
  parameter int ALUMODE_WIDTH = 4,
  parameter int OPMODE_WIDTH  = 7,
  parameter int INMODE_WIDTH  = 5,
  parameter int PC_WIDTH      = 4,
  parameter int EXEC_LAT      = 3,
  parameter int I_WIDTH       = 2 + 3*ADDR_WIDTH + ALUMODE_WIDTH + OPMODE_WIDTH + INMODE_WIDTH
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  dsp_prog_sequencer_if.slave bus
);

  // Field positions inside the instruction word
  localparam int R0_LSB  = 2;
  localparam int R1_LSB  = R0_LSB + ADDR_WIDTH;
  localparam int WA_LSB  = R1_LSB + ADDR_WIDTH;
  localparam int IN_LSB  = WA_LSB + ADDR_WIDTH;
  localparam int OP_LSB  = IN_LSB + INMODE_WIDTH;
  localparam int ALU_LSB = OP_LSB + OPMODE_WIDTH;

  localparam int CNT_W = $clog2(EXEC_LAT);

  // Final execute cycle, and the cycle before it (when the write enable is
  // armed so that it is a registered output during the final cycle).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(EXEC_LAT - 2);

  localparam logic [PC_WIDTH-1:0] PC_TOP = {PC_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e                   state_q;
  logic [PC_WIDTH-1:0]      pc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     exec_q;
  logic                     last_q;

  logic                     valid_q;
  logic                     busy_q;
  logic                     err_q;
  logic                     reb0_q;
  logic                     reb1_q;
  logic                     web1_q;
  logic [ALUMODE_WIDTH-1:0] alumode_q;
  logic [OPMODE_WIDTH-1:0]  opmode_q;
  logic [INMODE_WIDTH-1:0]  inmode_q;
  logic [ADDR_WIDTH-1:0]    b1_waddr_q;
  logic [ADDR_WIDTH-1:0]    b1_raddr_q;
  logic [ADDR_WIDTH-1:0]    b0_raddr_q;

  logic [I_WIDTH-1:0]       instr;
  logic                     fetch_go;
  logic                     ex_last;

  assign instr   = bus.imem_data_i;
  assign ex_last = (cnt_q == CNT_LAST);

`ifdef DSP_SEQ_HOLD_EN
  assign fetch_go = ~bus.hold_i;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      exec_q     <= 1'b0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      reb0_q     <= 1'b0;
      reb1_q     <= 1'b0;
      web1_q     <= 1'b0;
      alumode_q  <= '0;
      opmode_q   <= '0;
      inmode_q   <= '0;
      b1_waddr_q <= '0;
      b1_raddr_q <= '0;
      b0_raddr_q <= '0;
    end else begin
      case (state_q)
        // Wait for a start request; valid/err of the previous run stay
        // visible until a new program is accepted.
        S_IDLE: begin
          if (bus.start_i) begin
            pc_q    <= bus.start_pc_i;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end

        // ---- FETCH: PC is on imem_addr_o, memory answers next cycle ----
        S_FETCH: begin
          if (fetch_go) begin
            state_q <= S_DECODE;
          end
        end

        // ---- DECODE: register every field of the returned word ----
        S_DECODE: begin
          exec_q     <= instr[0];
          last_q     <= instr[1];
          reb0_q     <= instr[0];
          reb1_q     <= instr[0];
          b0_raddr_q <= instr[R0_LSB  +: ADDR_WIDTH];
          b1_raddr_q <= instr[R1_LSB  +: ADDR_WIDTH];
          b1_waddr_q <= instr[WA_LSB  +: ADDR_WIDTH];
          inmode_q   <= instr[IN_LSB  +: INMODE_WIDTH];
          opmode_q   <= instr[OP_LSB  +: OPMODE_WIDTH];
          alumode_q  <= instr[ALU_LSB +: ALUMODE_WIDTH];
          cnt_q      <= '0;
          state_q    <= S_EXEC;
        end

        // ---- EXECUTE: EXEC_LAT cycles, single write in the final one ----
        S_EXEC: begin
          cnt_q  <= cnt_q + 1'b1;
          web1_q <= exec_q && (cnt_q == CNT_ARM);
          if (ex_last) begin
            web1_q <= 1'b0;
            reb0_q <= 1'b0;
            reb1_q <= 1'b0;
            if (last_q) begin
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else if (pc_q == PC_TOP) begin
              // Ran off the end of program space: stop rather than wrap.
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end

        // A held start request must be released before a new run.
        S_DONE: begin
          valid_q <= 1'b1;
          if (!bus.start_i) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_addr_o    = pc_q;
  assign bus.valid_o        = valid_q;
  assign bus.busy_o         = busy_q;
  assign bus.err_o          = err_q;
  assign bus.bram0_reb_o    = reb0_q;
  assign bus.bram1_reb_o    = reb1_q;
  assign bus.bram1_web_o    = web1_q;
  assign bus.alumode_o      = alumode_q;
  assign bus.opmode_o       = opmode_q;
  assign bus.inmode_o       = inmode_q;
  assign bus.bram1_w_addr_o = b1_waddr_q;
  assign bus.bram1_r_addr_o = b1_raddr_q;
  assign bus.bram0_r_addr_o = b0_raddr_q;

endmodule

// File: tb/tb_dsp_prog_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsp_prog_sequencer
//
// Drives dsp_prog_sequencer through its interface with a behavioural
// instruction memory. Expected outputs for every cycle of a run come from a
// program-level model: the program is walked from start_pc (stop on "last" or
// at the top of program space), and each cycle is mapped to (instruction k,
// phase) with plain arithmetic on the per-instruction length 2+EXEC_LAT.
// -----------------------------------------------------------------------------
module tb_dsp_prog_sequencer;

  localparam int AW     = 5;
  localparam int ALW    = 4;
  localparam int OPW    = 7;
  localparam int INW    = 5;
  localparam int PCW    = 4;
  localparam int LAT    = 3;
  localparam int IW     = 2 + 3*AW + ALW + OPW + INW;
  localparam int P      = 2 + LAT;
  localparam int PC_TOP = (1 << PCW) - 1;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  dsp_prog_sequencer_if #(
    .ADDR_WIDTH(AW), .ALUMODE_WIDTH(ALW), .OPMODE_WIDTH(OPW),
    .INMODE_WIDTH(INW), .PC_WIDTH(PCW)
  ) bus ();

  dsp_prog_sequencer #(
    .ADDR_WIDTH(AW), .ALUMODE_WIDTH(ALW), .OPMODE_WIDTH(OPW),
    .INMODE_WIDTH(INW), .PC_WIDTH(PCW), .EXEC_LAT(LAT)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Synchronous-read instruction memory: word valid one cycle after address.
  logic [IW-1:0] imem [0:PC_TOP];
  always @(posedge clk_i) bus.imem_data_i <= imem[bus.imem_addr_o];

  int n_checks = 0;
  int n_fail   = 0;
  logic [IW-1:0] prev_word = '0;

  function automatic logic [IW-1:0] mk_word(
    input bit ex, input bit la,
    input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] wa,
    input logic [INW-1:0] in, input logic [OPW-1:0] op, input logic [ALW-1:0] alu);
    return {alu, op, in, wa, r1, r0, la, ex};
  endfunction

  function automatic logic [IW-1:0] rand_word(input bit ex, input bit la);
    return mk_word(ex, la, AW'($urandom), AW'($urandom), AW'($urandom),
                   INW'($urandom), OPW'($urandom), ALW'($urandom));
  endfunction

  // {alumode, opmode, inmode} of a word
  function automatic logic [ALW+OPW+INW-1:0] w_modes(input logic [IW-1:0] w);
    logic [INW-1:0] in;
    logic [OPW-1:0] op;
    logic [ALW-1:0] alu;
    in  = w[2+3*AW +: INW];
    op  = w[2+3*AW+INW +: OPW];
    alu = w[2+3*AW+INW+OPW +: ALW];
    return {alu, op, in};
  endfunction

  // {bram1_w_addr, bram1_r_addr, bram0_r_addr} of a word
  function automatic logic [3*AW-1:0] w_addrs(input logic [IW-1:0] w);
    return {w[2+2*AW +: AW], w[2+AW +: AW], w[2 +: AW]};
  endfunction

  function automatic logic [5:0] act_ctrl();
    return {bus.valid_o, bus.busy_o, bus.err_o,
            bus.bram0_reb_o, bus.bram1_reb_o, bus.bram1_web_o};
  endfunction

  function automatic logic [ALW+OPW+INW-1:0] act_modes();
    return {bus.alumode_o, bus.opmode_o, bus.inmode_o};
  endfunction

  function automatic logic [3*AW-1:0] act_addrs();
    return {bus.bram1_w_addr_o, bus.bram1_r_addr_o, bus.bram0_r_addr_o};
  endfunction

  // Runs one program from spc and checks every cycle. Called at #1 after a
  // posedge with the sequencer idle. hold_cyc stalls the first FETCH.
  task automatic run_prog(input logic [PCW-1:0] spc, input int hold_cyc,
                          input bit keep_start, input string tag);
    logic [IW-1:0]  prog [$];
    logic [PCW-1:0] pcs  [$];
    bit             exp_err;
    int             pc, n, tot, te, k, ph, total;
    bit             run, exb;
    logic [5:0]     e_ctrl;
    logic [IW-1:0]  e_word;
    logic [PCW-1:0] e_pc;

    exp_err = 1'b0;
    pc = int'(spc);
    for (int g = 0; g <= PC_TOP; g++) begin
      prog.push_back(imem[pc]);
      pcs.push_back(PCW'(pc));
      if (imem[pc][1]) break;
      if (pc == PC_TOP) begin
        exp_err = 1'b1;
        break;
      end
      pc++;
    end
    n     = prog.size();
    tot   = n * P;
    total = tot + 3 + hold_cyc;

    bus.start_pc_i = spc;
    bus.start_i    = 1'b1;
    @(posedge clk_i); #1;
    if (!keep_start) bus.start_i = 1'b0;
`ifdef DSP_SEQ_HOLD_EN
    bus.hold_i = (hold_cyc > 0);
`endif

    for (int t = 0; t < total; t++) begin
      if (t > 0) begin
        @(posedge clk_i); #1;
      end
      te  = (t <= hold_cyc) ? 0 : t - hold_cyc;
      run = (te < tot);
      k   = run ? te / P : n - 1;
      ph  = run ? te % P : P - 1;
      exb = prog[k][0];
      e_ctrl = {te >= tot + 1, run, exp_err && (te >= tot),
                run && ph >= 2 && exb, run && ph >= 2 && exb,
                run && ph == P - 1 && exb};
      e_pc   = pcs[k];
      e_word = (!run || ph >= 2) ? prog[k] : ((k > 0) ? prog[k-1] : prev_word);

      n_checks++;
      if (act_ctrl() !== e_ctrl) begin
        n_fail++;
        $display("FAIL %s ctrl t=%0d got v/b/e/r0/r1/w=%b want %b", tag, t, act_ctrl(), e_ctrl);
      end
      n_checks++;
      if (bus.imem_addr_o !== e_pc) begin
        n_fail++;
        $display("FAIL %s imem_addr t=%0d got %0d want %0d", tag, t, bus.imem_addr_o, e_pc);
      end
      n_checks++;
      if (act_modes() !== w_modes(e_word)) begin
        n_fail++;
        $display("FAIL %s modes t=%0d got %h want %h", tag, t, act_modes(), w_modes(e_word));
      end
      n_checks++;
      if (act_addrs() !== w_addrs(e_word)) begin
        n_fail++;
        $display("FAIL %s addrs t=%0d got %h want %h", tag, t, act_addrs(), w_addrs(e_word));
      end
`ifdef DSP_SEQ_HOLD_EN
      if (t == hold_cyc) bus.hold_i = 1'b0;
`endif
    end

    if (keep_start) begin
      e_ctrl = {1'b1, 1'b0, exp_err, 3'b000};
      for (int i = 0; i < 3; i++) begin
        @(posedge clk_i); #1;
        n_checks++;
        if (act_ctrl() !== e_ctrl || bus.imem_addr_o !== pcs[n-1]) begin
          n_fail++;
          $display("FAIL %s held_start ctrl=%b pc=%0d want %b pc=%0d", tag, act_ctrl(),
                   bus.imem_addr_o, e_ctrl, pcs[n-1]);
        end
      end
      bus.start_i = 1'b0;
      @(posedge clk_i); #1;
      n_checks++;
      if (act_ctrl() !== e_ctrl) begin
        n_fail++;
        $display("FAIL %s start_release ctrl got %b want %b", tag, act_ctrl(), e_ctrl);
      end
    end
    prev_word = prog[n-1];
  endtask

  task automatic test_reset();
    bus.start_i    = 1'b0;
    bus.start_pc_i = '0;
`ifdef DSP_SEQ_HOLD_EN
    bus.hold_i     = 1'b0;
`endif
    for (int i = 0; i <= PC_TOP; i++) imem[i] = '0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({act_ctrl(), bus.imem_addr_o, act_modes(), act_addrs()} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got %h want 0",
               {act_ctrl(), bus.imem_addr_o, act_modes(), act_addrs()});
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if ({act_ctrl(), bus.imem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset got %h want 0", {act_ctrl(), bus.imem_addr_o});
    end
    prev_word = '0;
  endtask

  task automatic test_single();
    imem[0] = mk_word(1'b1, 1'b1, 5'd2, 5'd1, 5'd3, 5'd0, 7'h35, 4'd0);
    run_prog(4'd0, 0, 1'b0, "single");
  endtask

  task automatic test_three();
    imem[4] = rand_word(1'b1, 1'b0);
    imem[5] = rand_word(1'b1, 1'b0);
    imem[6] = rand_word(1'b1, 1'b1);
    run_prog(4'd4, 0, 1'b0, "three");
  endtask

  task automatic test_nop();
    imem[4] = rand_word(1'b1, 1'b0);
    imem[5] = rand_word(1'b0, 1'b0);
    imem[6] = rand_word(1'b1, 1'b1);
    run_prog(4'd4, 0, 1'b0, "nop");
  endtask

  task automatic test_err();
    imem[14] = rand_word(1'b1, 1'b0);
    imem[15] = rand_word(1'b1, 1'b0);
    imem[0]  = rand_word(1'b1, 1'b1);
    run_prog(4'd14, 0, 1'b0, "err");
    // next run must clear err_o on accept
    imem[3] = rand_word(1'b1, 1'b1);
    run_prog(4'd3, 0, 1'b0, "err_clear");
  endtask

  task automatic test_reset_mid();
    imem[4] = rand_word(1'b1, 1'b0);
    imem[5] = rand_word(1'b1, 1'b0);
    imem[6] = rand_word(1'b1, 1'b1);
    bus.start_pc_i = 4'd4;
    bus.start_i    = 1'b1;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    repeat (P + 3) @(posedge clk_i);
    #1;
    n_checks++;
    if (act_ctrl() !== 6'b010110) begin
      n_fail++;
      $display("FAIL mid_ex1_state got %b want 010110", act_ctrl());
    end
    #1 rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({act_ctrl(), bus.imem_addr_o, act_modes(), act_addrs()} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got %h want 0",
               {act_ctrl(), bus.imem_addr_o, act_modes(), act_addrs()});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      n_checks++;
      if (act_ctrl() !== '0) begin
        n_fail++;
        $display("FAIL reset_hold ctrl got %b want 000000", act_ctrl());
      end
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    prev_word = '0;
    run_prog(4'd4, 0, 1'b0, "after_reset");
  endtask

  task automatic test_start_held();
    imem[8] = rand_word(1'b1, 1'b0);
    imem[9] = rand_word(1'b1, 1'b1);
    run_prog(4'd8, 0, 1'b1, "start_held");
    run_prog(4'd8, 0, 1'b0, "restart");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int spc;
      int len;
      spc = $urandom_range(0, PC_TOP);
      len = $urandom_range(1, 4);
      for (int i = 0; i <= PC_TOP; i++) imem[i] = rand_word(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) != 0 && spc + len - 1 <= PC_TOP) imem[spc+len-1][1] = 1'b1;
      run_prog(PCW'(spc), 0, (r == 2), "random");
    end
  endtask

`ifdef DSP_SEQ_HOLD_EN
  task automatic test_hold();
    imem[4] = rand_word(1'b1, 1'b0);
    imem[5] = rand_word(1'b1, 1'b0);
    imem[6] = rand_word(1'b1, 1'b1);
    run_prog(4'd4, 4, 1'b0, "hold");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_three();
    test_nop();
    test_err();
    test_reset_mid();
    test_start_held();
    test_random();
`ifdef DSP_SEQ_HOLD_EN
    test_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dsp_prog_sequencer.md
Name: dsp_prog_sequencer

Overview:
Parametrised successor of the single-instruction DSP controller. It runs a program of DSP48 instructions from an external instruction memory, starting at a given address and stopping at an instruction flagged "last". Each instruction is decoded into DSP48 mode fields and BRAM addresses and enables, with a configurable execute latency. It sits between the host start/valid handshake, the instruction memory, BRAM0/BRAM1 and the DSP48 slice.

Parameters:
ADDR_WIDTH, 5, BRAM address width
ALUMODE_WIDTH, 4, DSP48 ALUMODE width
OPMODE_WIDTH, 7, DSP48 OPMODE width
INMODE_WIDTH, 5, DSP48 INMODE width
PC_WIDTH, 4, instruction-memory address width; program space is 2**PC_WIDTH entries
EXEC_LAT, 3, execute cycles per instruction (legal range 2..16)
I_WIDTH, 2+3*ADDR_WIDTH+ALUMODE_WIDTH+OPMODE_WIDTH+INMODE_WIDTH (33), derived instruction width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  level start request from host
start_pc_i  in  PC_WIDTH  first instruction address, sampled when start is accepted
imem_addr_o  out  PC_WIDTH  instruction-memory read address (equals PC)
imem_data_i  in  I_WIDTH  instruction word, valid 1 cycle after the address
valid_o  out  1  program complete
busy_o  out  1  high in every state except IDLE and DONE
err_o  out  1  PC reached the top of program space without a "last" flag
bram0_reb_o, bram1_reb_o, bram1_web_o  out  1 each  BRAM enables
alumode_o / opmode_o / inmode_o  out  field widths  DSP48 modes
bram1_w_addr_o, bram1_r_addr_o, bram0_r_addr_o  out  ADDR_WIDTH each  BRAM addresses

Behaviour:
- Instruction layout, LSB first: [0] exec; [1] last; bram0_r_addr; bram1_r_addr; bram1_w_addr; inmode; opmode; alumode.
- Reset: every output 0, PC 0, FSM in IDLE, exec counter 0. Reset takes effect immediately, including mid-program; no BRAM write may occur after rst_ni falls.
- States and transitions:
  - IDLE: start_i=1 loads PC=start_pc_i and clears err_o; next state FETCH.
  - FETCH: imem_addr_o=PC; next state DECODE.
  - DECODE: register all fields from imem_data_i; reb outputs = exec bit; counter=0; next state EXECUTE.
  - EXECUTE: counter increments each cycle. bram1_web_o is high only in the cycle where counter==EXEC_LAT-1 and exec=1 (exactly one write per instruction). On that cycle:
    - last=1 → DONE;
    - else PC==2**PC_WIDTH-1 → set err_o, go to DONE;
    - else PC+1 → FETCH.
  - DONE: valid_o=1, reb/web=0; returns to IDLE when start_i=0.
- Mode and address outputs hold their last decoded values until the next DECODE.
- Timing: for N instructions, valid_o rises at rising edge 1+N*(2+EXEC_LAT) after the edge that samples start_i in IDLE.
- start_i changes while busy are ignored. A new program needs start_i to go 0 then 1.
- exec=0 is a NOP: same cycle count, all enables low, mode fields still updated.
- err_o holds until the next accepted start or reset.
- PC never wraps.

Optional Feature:
DSP_SEQ_HOLD_EN
- Defined: adds input port hold_i (1 bit). While hold_i=1 in FETCH, the FSM stays in FETCH with all enables low and PC unchanged. Holds in other states have no effect until the next FETCH.
- Undefined: no hold_i port; FETCH always advances.

Test Plan:
1. One instruction, start_pc_i=0, word{exec=1,last=1,alumode=0,opmode=7'h35,inmode=0,w=3,r1=1,r0=2} → opmode_o=7'h35 and addresses 3/1/2 from EX0; single web pulse at EX2; valid_o at edge 6.
2. Three-instruction program at PC 4..6, last on PC 6 → imem_addr_o sequence 4,5,6; exactly 3 web pulses; valid_o at edge 16.
3. Middle instruction exec=0 → no reb/web during its execute; cycle count unchanged; other two write normally.
4. Program with no last flag from start_pc_i=14 (PC_WIDTH=4) → executes PC 14,15; err_o=1; valid_o=1; no wrap to 0.
5. rst_ni low during EX1 of the second instruction → all outputs 0 asynchronously, no web pulse; start after reset reruns cleanly.
6. start_i held high through DONE → valid_o stays 1 and no restart; drop start_i → IDLE; reassert → new run. With DSP_SEQ_HOLD_EN, hold_i=1 for 4 cycles in FETCH → completion delayed by exactly 4 cycles.
